// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: ALU operations, forwarding selects
// and result-source selects.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/iexecute_alu.sv
// Combinational RV32I ALU: arithmetic wraps modulo 2^XLEN, no overflow trap.
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      control,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    always_comb begin
        result = '0;
        case (control)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/iexecute.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution and the EX/MEM pipeline register.
module iexecute
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    // Select code 11 is reserved and behaves like the register value.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_v,
        input logic [XLEN-1:0] wb_v,
        input logic [XLEN-1:0] mem_v
    );
        case (sel)
            FWD_WB:  return wb_v;
            FWD_MEM: return mem_v;
            default: return reg_v;
        endcase
    endfunction

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;

    logic            reg_write_d,  reg_write_q;
    logic            mem_write_d,  mem_write_q;
    logic [1:0]      result_src_d, result_src_q;
    logic [4:0]      rd_d,         rd_q;
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [XLEN-1:0] write_data_d, write_data_q;
    logic [XLEN-1:0] pc_plus4_d,   pc_plus4_q;

    // MEM-stage forwarding taps this stage's own registered ALU result.
    assign src_a_e      = fwd_sel(ForwardAE, RD1E, ResultW, alu_result_q);
    assign write_data_e = fwd_sel(ForwardBE, RD2E, ResultW, alu_result_q);
    assign src_b_e      = ALUSrcE ? ImmExtE : write_data_e;

    alu #(.XLEN(XLEN)) u_alu (
        .a       (src_a_e),
        .b       (src_b_e),
        .control (ALUControlE),
        .result  (alu_result_e),
        .zero    (zero_e)
    );

    assign PCTargetE = PCE + ImmExtE;
    assign PCSrcE    = (BranchE & zero_e) | JumpE;

    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RdE;
        alu_result_d = alu_result_e;
        write_data_d = write_data_e;
        pc_plus4_d   = PCPlus4E;
    end

    // EX/MEM boundary: loads every cycle, reset inserts a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemWriteM  = mem_write_q;
    assign ResultSrcM = result_src_q;
    assign RdM        = rd_q;
    assign ALUResultM = alu_result_q;
    assign WriteDataM = write_data_q;
    assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_iexecute.sv
// Directed bench for the execute stage with a scoreboard of expected EX/MEM contents.
module tb_iexecute;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    always #5 clk = ~clk;

    iexecute #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    typedef struct packed {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prev_alu = '0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_fwd(input logic [1:0] sel, input logic [31:0] r);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return prev_alu;
        return r;
    endfunction

    function automatic logic [31:0] model_result();
        logic [31:0] a, b;
        a = model_fwd(ForwardAE, RD1E);
        b = ALUSrcE ? ImmExtE : model_fwd(ForwardBE, RD2E);
        return model_alu(ALUControlE, a, b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        logic exp_src;
        #1;
        exp_src = (BranchE & (model_result() == 32'd0)) | JumpE;
        check("pcsrc", {31'd0, PCSrcE}, {31'd0, exp_src});
        check("pctarget", PCTargetE, PCE + ImmExtE);
    endtask

    task automatic tick();
        exp_t e;
        e = '0;
        if (!reset) begin
            e.rw  = RegWriteE;
            e.mw  = MemWriteE;
            e.rs  = ResultSrcE;
            e.rd  = RdE;
            e.alu = model_result();
            e.wd  = model_fwd(ForwardBE, RD2E);
            e.pc4 = PCPlus4E;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        prev_alu = e.alu;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("regwrite_m", {31'd0, RegWriteM}, {31'd0, e.rw});
            check("memwrite_m", {31'd0, MemWriteM}, {31'd0, e.mw});
            check("resultsrc_m", {30'd0, ResultSrcM}, {30'd0, e.rs});
            check("rd_m", {27'd0, RdM}, {27'd0, e.rd});
            check("aluresult_m", ALUResultM, e.alu);
            check("writedata_m", WriteDataM, e.wd);
            check("pcplus4_m", PCPlus4M, e.pc4);
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControlE = op; RD1E = a; RD2E = b;
        ALUSrcE = 1'b0; ForwardAE = FWD_REG; ForwardBE = FWD_REG;
        BranchE = 1'b0; JumpE = 1'b0; ResultSrcE = RES_ALU;
    endtask

    initial begin
        // Reset held two cycles with nonzero inputs.
        reset = 1'b1;
        RegWriteE = 1'b1; MemWriteE = 1'b1; JumpE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0;
        ResultSrcE = RES_MEM; ALUControlE = ALU_ADD; RdE = 5'd3;
        RD1E = 32'd11; RD2E = 32'd22; PCE = 32'h40; ImmExtE = 32'h8; PCPlus4E = 32'h44;
        ForwardAE = FWD_REG; ForwardBE = FWD_REG; ResultW = 32'd0;
        @(negedge clk);
        tick();
        tick();
        check("reset_alu_zero", ALUResultM, 32'd0);

        // Release: next edge captures the inputs.
        reset = 1'b0;
        tick();
        check("release_alu", ALUResultM, 32'd33);

        // Plain add.
        set_op(ALU_ADD, 32'd5, 32'd7); RegWriteE = 1'b1; MemWriteE = 1'b0; RdE = 5'd1;
        check_comb();
        tick();
        check("add_5_7", ALUResultM, 32'd12);
        check("add_wd", WriteDataM, 32'd7);

        // Signed vs unsigned compare, sub wrap.
        set_op(ALU_SLT, 32'hFFFFFFFF, 32'd1);  tick(); check("slt", ALUResultM, 32'd1);
        set_op(ALU_SLTU, 32'hFFFFFFFF, 32'd1); tick(); check("sltu", ALUResultM, 32'd0);
        set_op(ALU_SUB, 32'd0, 32'd1);         tick(); check("sub_wrap", ALUResultM, 32'hFFFFFFFF);

        // Remaining ops including the 111 code.
        for (int op = 2; op < 8; op++) begin
            if (op == 5 || op == 6) continue;
            set_op(op[2:0], 32'hF0F0_1234, 32'h0FF0_4321);
            tick();
        end

        // Back-to-back forwarding from MEM, then from WB.
        set_op(ALU_ADD, 32'd3, 32'd4); tick();
        set_op(ALU_ADD, 32'd99, 32'd0); ALUSrcE = 1'b1; ImmExtE = 32'd1; ForwardAE = FWD_MEM;
        tick();
        check("fwd_mem", ALUResultM, 32'd8);
        ForwardAE = FWD_WB; ResultW = 32'd20;
        tick();
        check("fwd_wb", ALUResultM, 32'd21);

        // Forward B from MEM lands in WriteDataM; reserved select 11 uses the register.
        set_op(ALU_OR, 32'd0, 32'd5); ForwardBE = FWD_MEM; MemWriteE = 1'b1;
        tick();
        check("fwd_b_mem_wd", WriteDataM, 32'd21);
        set_op(ALU_ADD, 32'd6, 32'd2); ForwardAE = 2'b11; ForwardBE = 2'b11; MemWriteE = 1'b0;
        tick();
        check("fwd_reserved", ALUResultM, 32'd8);

        // beq taken and not taken.
        set_op(ALU_SUB, 32'd9, 32'd9); BranchE = 1'b1; RegWriteE = 1'b0;
        PCE = 32'h100; ImmExtE = 32'hFFFFFFF8;
        check_comb();
        check("beq_taken", {31'd0, PCSrcE}, 32'd1);
        check("beq_target", PCTargetE, 32'hF8);
        tick();
        set_op(ALU_SUB, 32'd9, 32'd4); BranchE = 1'b1;
        check_comb();
        check("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
        tick();

        // Branch and jump together.
        set_op(ALU_SUB, 32'd1, 32'd2); BranchE = 1'b1; JumpE = 1'b1;
        check_comb();
        tick();

        // jal, then reset discards the following instruction.
        set_op(ALU_ADD, 32'd0, 32'd0); JumpE = 1'b1; ResultSrcE = RES_PC4;
        RegWriteE = 1'b1; RdE = 5'd0; PCPlus4E = 32'h24;
        check_comb();
        check("jal_pcsrc", {31'd0, PCSrcE}, 32'd1);
        tick();
        check("jal_pc4", PCPlus4M, 32'h24);
        check("jal_ressrc", {30'd0, ResultSrcM}, 32'd2);
        check("jal_regwrite", {31'd0, RegWriteM}, 32'd1);
        reset = 1'b1;
        tick();
        check("reset_midstream", {31'd0, RegWriteM}, 32'd0);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iexecute.md
Name: iexecute

Overview:
- Execute (EX) stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX register outputs from the decode stage and selects operands through forwarding muxes. Computes the ALU result and the branch/jump target, and resolves PCSrc for fetch.
- Registers everything the memory stage needs in an internal EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  stage clock, rising edge
- reset  in  1  synchronous, active-high; clears the EX/MEM register
- RegWriteE  in  1  register-file write enable (ID/EX)
- MemWriteE  in  1  data-memory write enable
- JumpE  in  1  jal/jalr
- BranchE  in  1  beq
- ALUSrcE  in  1  0: SrcB=forwarded RD2E; 1: SrcB=ImmExtE
- ResultSrcE  in  2  00 ALU, 01 memory, 10 PC+4 (passed through)
- ALUControlE  in  3  ALU operation
- RdE  in  5  destination register
- RD1E, RD2E  in  XLEN  register operands
- PCE, ImmExtE, PCPlus4E  in  XLEN  PC, extended immediate, PC+4
- ForwardAE, ForwardBE  in  2  00 register, 01 ResultW, 10 ALUResultM (from hazard unit)
- ResultW  in  XLEN  writeback result
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  XLEN  PCE+ImmExtE (combinational)
- RegWriteM, MemWriteM  out  1  registered controls
- ResultSrcM  out  2  registered
- RdM  out  5  registered
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered

Behaviour:
- Clocking: one clock, clk. reset is synchronous and active-high and is sampled only at the rising edge of clk.
- Reset: every registered output is 0. RegWriteM=0 and MemWriteM=0 make the slot a bubble. Asserting reset mid-stream discards the in-flight EX instruction at that edge.
- SrcAE mux on ForwardAE:
  - 00: RD1E
  - 01: ResultW
  - 10: ALUResultM, taken from this block's own registered output
  - 11: RD1E (reserved)
- WriteDataE: the same mux applied to RD2E with ForwardBE. SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, combinational, modulo 2^XLEN, no overflow trap:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt (signed compare, result 0 or 1)
  - 110 sltu
  - 111 result 0
- ZeroE = (ALUResultE == 0).
- PCTargetE = PCE + ImmExtE, wrapping.
- PCSrcE = (BranchE & ZeroE) | JumpE, combinational within the same cycle. Flushing of fetch and decode is done by the hazard unit, not here.
- EX/MEM register: on each rising edge with reset low it captures:
  - RegWriteE, MemWriteE, ResultSrcE, RdE
  - ALUResultE, WriteDataE (the forwarded value, not raw RD2E), PCPlus4E
- Latency: EX outputs are valid 1 cycle after the ID/EX values.
- The register has no stall or enable input; it loads every cycle.
- Forwarding from ALUResultM reads the value from the previous cycle's instruction, so back-to-back dependent ALU ops complete without a bubble.
- Simultaneous BranchE and JumpE: PCSrcE=1.
- RdE=0 passes through unchanged; suppressing the x0 write is the register file's job.

Decomposition:
- riscv_pkg:
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU.
  - Forward-select constants: FWD_REG, FWD_WB, FWD_MEM.
  - ResultSrc constants: RES_ALU, RES_MEM, RES_PC4.
- Sub-module alu (operands a and b, control, result, zero) holds the operation case logic.
- The EX/MEM register stays inline in iexecute.

Test Plan:
- Reset held 2 cycles with nonzero inputs -> all M outputs 0. Release -> the next edge captures the inputs.
- RD1E=5, RD2E=7, ALUControlE=000, ALUSrcE=0, Forward*=00 -> ALUResultM=12 and WriteDataM=7 one cycle later.
- slt/sltu with RD1E=32'hFFFFFFFF, RD2E=1 -> slt gives 1, sltu gives 0. Sub with 0 and 1 gives 32'hFFFFFFFF.
- Back-to-back: add x1=3+4, then add x2=x1+1 with ForwardAE=10 -> second ALUResultM=8. With ForwardAE=01 and ResultW=20 -> 21.
- beq with RD1E=RD2E=9, BranchE=1, PCE=32'h100, ImmExtE=32'hFFFFFFF8 -> PCSrcE=1 and PCTargetE=32'hF8 in the same cycle. With unequal operands -> PCSrcE=0.
- jal with JumpE=1, PCPlus4E=32'h24, ResultSrcE=10 -> PCSrcE=1, then PCPlus4M=32'h24, ResultSrcM=10, RegWriteM=1. Reset asserted in the following cycle -> RegWriteM=0.
